riscv_mu_ras_cache_mem: RTL

- Storage stage directly downstream of riscv_mu_cache_access_unit. It consumes that unit's o_cache_write, o_cache_read, o_cache_wr_data, o_cache_wr_addr and o_cache_rd_addr.
- Holds spilled return addresses in a small tagged, direct-mapped array, fronted by a write buffer with read forwarding.
- Returns read data one cycle after each read request, with a hit flag.
- Supports a walking flush that invalidates every entry.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/riscv_rm_write_buffer.sv | 91 +++++++++
 rtl/riscv_mu_ras_cache_mem.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the RAS spill storage stage: FSM states and write-buffer entries.
package riscv_pkg;

    localparam int RAS_ADDR_WIDTH = 64;
    localparam int RAS_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        RM_IDLE  = 2'd0,
        RM_RUN   = 2'd1,
        RM_FLUSH = 2'd2
    } ras_mem_state_e;

    typedef struct packed {
        logic [RAS_ADDR_WIDTH-1:0] addr;
        logic [RAS_DATA_WIDTH-1:0] data;
    } ras_wb_entry_t;

endpackage

// File: rtl/riscv_rm_write_buffer.sv
// Circular write buffer with a youngest-match associative lookup port.
module riscv_rm_write_buffer
    import riscv_pkg::*;
#(
    parameter int WB_DEPTH   = 4,
    parameter int ADDR_WIDTH = RAS_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAS_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic                        clear,
    input  logic                        push,
    input  logic [ADDR_WIDTH-1:0]       push_addr,
    input  logic [DATA_WIDTH-1:0]       push_data,
    input  logic                        pop,
    output logic [ADDR_WIDTH-1:0]       head_addr,
    output logic [DATA_WIDTH-1:0]       head_data,
    output logic [$clog2(WB_DEPTH):0]   count,
    output logic                        full,
    input  logic [ADDR_WIDTH-1:0]       lookup_addr,
    output logic                        lookup_hit,
    output logic [DATA_WIDTH-1:0]       lookup_data
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ras_wb_entry_t      mem [WB_DEPTH];
    ras_wb_entry_t      push_entry;
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;

    always_comb begin
        push_entry      = '0;
        push_entry.addr = push_addr;
        push_entry.data = push_data;
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[tail_q] <= push_entry;
        end
    end

    // Pointers wrap naturally at WB_DEPTH; the count disambiguates full from empty.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (clear) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Scan oldest to youngest so the last live match seen wins.
    always_comb begin
        logic [PTR_W-1:0] slot;
        slot        = '0;
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            slot = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (mem[slot].addr == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = mem[slot].data;
            end
        end
    end

    assign head_addr = mem[head_q].addr;
    assign head_data = mem[head_q].data;
    assign count     = count_q;
    assign full      = (count_q == CNT_W'(WB_DEPTH));

endmodule

// File: rtl/riscv_mu_ras_cache_mem.sv
// Direct-mapped tagged store for spilled return addresses, fronted by a
// forwarding write buffer, with a walking flush that invalidates every entry.
module riscv_mu_ras_cache_mem
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int WB_DEPTH   = 4,
    parameter int FSM_WIDTH  = 2
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    enable,
    input  logic                    i_flush,
    input  logic                    i_cache_write,
    input  logic                    i_cache_read,
    input  logic [DATA_WIDTH-1:0]   i_cache_wr_data,
    input  logic [ADDR_WIDTH-1:0]   i_cache_wr_addr,
    input  logic [ADDR_WIDTH-1:0]   i_cache_rd_addr,
    output logic                    o_rd_valid,
    output logic                    o_rd_hit,
    output logic [DATA_WIDTH-1:0]   o_rd_data,
    output logic                    o_wb_full,
    output logic                    o_overflow,
    output logic                    o_busy,
    output logic [FSM_WIDTH-1:0]    o_fsm_status
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = ADDR_WIDTH - IDX_W;
    localparam int CNT_W = $clog2(WB_DEPTH) + 1;

    ras_mem_state_e         state_q;
    ras_mem_state_e         state_d;
    logic [IDX_W-1:0]       flush_ptr_q;
    logic [IDX_W-1:0]       flush_ptr_d;

    logic [DEPTH-1:0]       valid_q;
    logic [TAG_W-1:0]       tag_mem  [DEPTH];
    logic [DATA_WIDTH-1:0]  data_mem [DEPTH];

    logic                   run;
    logic                   wr_req;
    logic                   do_push;
    logic                   do_drain;
    logic                   wb_clear;
    logic                   wb_full;
    logic [CNT_W-1:0]       wb_count;
    logic [ADDR_WIDTH-1:0]  wb_head_addr;
    logic [DATA_WIDTH-1:0]  wb_head_data;
    logic                   wb_lookup_hit;
    logic [DATA_WIDTH-1:0]  wb_lookup_data;

    logic [IDX_W-1:0]       rd_idx;
    logic [TAG_W-1:0]       rd_tag;
    logic [IDX_W-1:0]       drain_idx;
    logic [TAG_W-1:0]       drain_tag;
    logic                   rd_hit_d;
    logic [DATA_WIDTH-1:0]  rd_data_d;

    logic                   rd_valid_q;
    logic                   rd_hit_q;
    logic [DATA_WIDTH-1:0]  rd_data_q;
    logic                   overflow_q;

    // The array is single-ported, so draining only happens in read-free cycles;
    // a flush request discards the buffer instead of draining it.
    assign run      = enable && (state_q == RM_RUN);
    assign wb_clear = run && i_flush;
    assign do_drain = run && !i_flush && !i_cache_read && (wb_count != '0);
    assign wr_req   = run && !i_flush && i_cache_write;
    assign do_push  = wr_req && (!wb_full || do_drain);

    assign rd_idx    = i_cache_rd_addr[IDX_W-1:0];
    assign rd_tag    = i_cache_rd_addr[ADDR_WIDTH-1:IDX_W];
    assign drain_idx = wb_head_addr[IDX_W-1:0];
    assign drain_tag = wb_head_addr[ADDR_WIDTH-1:IDX_W];

    riscv_rm_write_buffer #(
        .WB_DEPTH   (WB_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_write_buffer (
        .clk         (clk),
        .nreset      (nreset),
        .clear       (wb_clear),
        .push        (do_push),
        .push_addr   (i_cache_wr_addr),
        .push_data   (i_cache_wr_data),
        .pop         (do_drain),
        .head_addr   (wb_head_addr),
        .head_data   (wb_head_data),
        .count       (wb_count),
        .full        (wb_full),
        .lookup_addr (i_cache_rd_addr),
        .lookup_hit  (wb_lookup_hit),
        .lookup_data (wb_lookup_data)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= RM_IDLE;
            flush_ptr_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_ptr_q <= flush_ptr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_ptr_d = flush_ptr_q;
        if (enable) begin
            case (state_q)
                RM_IDLE: state_d = RM_RUN;
                RM_RUN: begin
                    if (i_flush) begin
                        state_d     = RM_FLUSH;
                        flush_ptr_d = '0;
                    end
                end
                RM_FLUSH: begin
                    if (i_flush) begin
                        flush_ptr_d = '0;
                    end else if (flush_ptr_q == IDX_W'(DEPTH - 1)) begin
                        state_d     = RM_RUN;
                        flush_ptr_d = '0;
                    end else begin
                        flush_ptr_d = flush_ptr_q + 1'b1;
                    end
                end
                default: begin
                    state_d     = RM_IDLE;
                    flush_ptr_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            valid_q <= '0;
        end else if (enable && (state_q == RM_FLUSH)) begin
            valid_q[flush_ptr_q] <= 1'b0;
        end else if (do_drain) begin
            valid_q[drain_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_drain) begin
            tag_mem[drain_idx]  <= drain_tag;
            data_mem[drain_idx] <= wb_head_data;
        end
    end

    // Forwarded buffer data outranks the array; outside RUN every read misses.
    always_comb begin
        rd_hit_d  = 1'b0;
        rd_data_d = '0;
        if (run && i_cache_read) begin
            if (wb_lookup_hit) begin
                rd_hit_d  = 1'b1;
                rd_data_d = wb_lookup_data;
            end else if (valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag)) begin
                rd_hit_d  = 1'b1;
                rd_data_d = data_mem[rd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_valid_q <= enable && i_cache_read;
            rd_hit_q   <= rd_hit_d;
            rd_data_q  <= rd_data_d;
            if (wr_req && !do_push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign o_rd_valid   = rd_valid_q;
    assign o_rd_hit     = rd_hit_q;
    assign o_rd_data    = rd_data_q;
    assign o_wb_full    = wb_full;
    assign o_overflow   = overflow_q;
    assign o_busy       = (state_q == RM_FLUSH);
    assign o_fsm_status = FSM_WIDTH'(state_q);

endmodule
